// File: rtl/ccu_ctrl_pkg.sv
// Shared types and constants for the CCU control slice.
// Default snoop channel types used by ccu_snoop_arbiter and its bench.
package ccu_ctrl_pkg;

  localparam int unsigned CCU_SNOOP_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ccu_ac_chan_t;

  typedef struct packed {
    logic WasUnique;
    logic IsShared;
    logic PassDirty;
    logic Error;
    logic DataTransfer;
  } ccu_cr_resp_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } ccu_cd_chan_t;

  typedef logic [1:0] ccu_domain_mask_t;

endpackage

// File: rtl/ccu_snoop_owner_router.sv
// Owner FIFO plus valid/ready demux: routes an in-order response stream to
// the requester recorded at the FIFO head; pops on the beat flagged last.
module ccu_snoop_owner_router
  import ccu_ctrl_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned Depth  = CCU_SNOOP_MAX_OUTSTANDING,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [IdxW-1:0]   push_idx_i,
  output logic              full_o,
  input  logic              up_valid_i,
  input  logic              up_last_i,
  input  logic              up_gate_i,
  output logic              up_ready_o,
  output logic [NumReq-1:0] dn_valid_o,
  input  logic [NumReq-1:0] dn_ready_i,
  output logic [IdxW-1:0]   head_o,
  output logic              pending_o
);

  localparam type req_idx_t = logic [IdxW-1:0];

  req_idx_t head;
  logic     head_valid, pop;

  stream_fifo #(
    .Depth  (Depth),
    .data_t (req_idx_t)
  ) i_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_i),
    .data_i  (push_idx_i),
    .full_o  (full_o),
    .pop_i   (pop),
    .data_o  (head),
    .valid_o (head_valid)
  );

  always_comb begin
    dn_valid_o       = '0;
    dn_valid_o[head] = up_valid_i && head_valid;
  end

  // A response with no recorded owner is never acknowledged.
  assign up_ready_o = dn_ready_i[head] && head_valid && up_gate_i;
  assign pop        = up_valid_i && up_ready_o && up_last_i;
  assign head_o     = head;
  assign pending_o  = head_valid;

endmodule

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with registered full/valid flags.
// A push while full is dropped, even if a pop happens in the same cycle.
module stream_fifo #(
  parameter int unsigned Depth = 4,
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  data_t data_i,
  output logic  full_o,
  input  logic  pop_i,
  output data_t data_o,
  output logic  valid_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  typedef logic [PtrW-1:0] ptr_t;

  data_t           mem_q [Depth];
  ptr_t            wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  function automatic ptr_t incr(ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= incr(wptr_q);
      if (do_pop)  rptr_q <= incr(rptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/ccu_snoop_arbiter.sv
// Shares the snoop-crossbar AC/CR/CD port between NumReq snoop controllers.
// Define CCU_SNOOP_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module ccu_snoop_arbiter
  import ccu_ctrl_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = CCU_SNOOP_MAX_OUTSTANDING,
  parameter type ac_chan_t              = ccu_ac_chan_t,
  parameter type cr_resp_t              = ccu_cr_resp_t,
  parameter type cd_chan_t              = ccu_cd_chan_t,
  parameter type domain_mask_t          = ccu_domain_mask_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumReq-1:0]          req_ac_valid_i,
  output logic [NumReq-1:0]          req_ac_ready_o,
  input  ac_chan_t [NumReq-1:0]      req_ac_i,
  input  domain_mask_t [NumReq-1:0]  req_domain_mask_i,
  output logic [NumReq-1:0]          req_cr_valid_o,
  input  logic [NumReq-1:0]          req_cr_ready_i,
  output cr_resp_t                   req_cr_resp_o,
  output logic [NumReq-1:0]          req_cd_valid_o,
  input  logic [NumReq-1:0]          req_cd_ready_i,
  output cd_chan_t                   req_cd_o,
  output logic                       ac_valid_o,
  input  logic                       ac_ready_i,
  output ac_chan_t                   ac_o,
  output domain_mask_t               domain_mask_o,
  input  logic                       cr_valid_i,
  output logic                       cr_ready_o,
  input  cr_resp_t                   cr_resp_i,
  input  logic                       cd_valid_i,
  output logic                       cd_ready_o,
  input  cd_chan_t                   cd_i,
  output logic                       busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam type req_idx_t = logic [IdxW-1:0];

  req_idx_t arb_idx, grant_idx, lock_idx_q, own_head, cd_head_unused;
  logic     lock_q, any_valid, ac_hs, own_full, own_pending;
  logic     cd_full, cd_pending, cr_gate, cd_push;

`ifdef CCU_SNOOP_ARB_RR_EN
  req_idx_t rr_q;

  // Walk backwards so the requester closest to the pointer wins.
  always_comb begin
    arb_idx = rr_q;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_ac_valid_i[req_idx_t'((int'(rr_q) + i) % int'(NumReq))])
        arb_idx = req_idx_t'((int'(rr_q) + i) % int'(NumReq));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else if (ac_hs)
      rr_q <= (grant_idx == req_idx_t'(NumReq - 1)) ? '0 : grant_idx + req_idx_t'(1);
  end
`else
  always_comb begin
    arb_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_ac_valid_i[req_idx_t'(i)]) arb_idx = req_idx_t'(i);
    end
  end
`endif

  // A stalled AC keeps its grant so the payload stays stable until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= ac_valid_o && !ac_ready_i;
      if (ac_valid_o && !ac_ready_i) lock_idx_q <= grant_idx;
    end
  end

  assign grant_idx     = lock_q ? lock_idx_q : arb_idx;
  assign any_valid     = |req_ac_valid_i;
  assign ac_valid_o    = any_valid && !own_full;
  assign ac_o          = req_ac_i[grant_idx];
  assign domain_mask_o = req_domain_mask_i[grant_idx];
  assign ac_hs         = ac_valid_o && ac_ready_i;

  always_comb begin
    req_ac_ready_o            = '0;
    req_ac_ready_o[grant_idx] = any_valid && ac_ready_i && !own_full;
  end

  // A data-carrying CR needs room to record its CD owner.
  assign cr_gate = !cd_full || !cr_resp_i.DataTransfer;
  assign cd_push = cr_valid_i && cr_ready_o && cr_resp_i.DataTransfer;

  ccu_snoop_owner_router #(
    .NumReq (NumReq),
    .Depth  (MaxOutstanding)
  ) i_cr_router (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (ac_hs),
    .push_idx_i (grant_idx),
    .full_o     (own_full),
    .up_valid_i (cr_valid_i),
    .up_last_i  (1'b1),
    .up_gate_i  (cr_gate),
    .up_ready_o (cr_ready_o),
    .dn_valid_o (req_cr_valid_o),
    .dn_ready_i (req_cr_ready_i),
    .head_o     (own_head),
    .pending_o  (own_pending)
  );

  ccu_snoop_owner_router #(
    .NumReq (NumReq),
    .Depth  (MaxOutstanding)
  ) i_cd_router (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (cd_push),
    .push_idx_i (own_head),
    .full_o     (cd_full),
    .up_valid_i (cd_valid_i),
    .up_last_i  (cd_i.last),
    .up_gate_i  (1'b1),
    .up_ready_o (cd_ready_o),
    .dn_valid_o (req_cd_valid_o),
    .dn_ready_i (req_cd_ready_i),
    .head_o     (cd_head_unused),
    .pending_o  (cd_pending)
  );

  assign req_cr_resp_o = cr_resp_i;
  assign req_cd_o      = cd_i;
  assign busy_o        = own_pending || cd_pending || lock_q;

`ifndef SYNTHESIS
  a_cr_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cr_valid_i |-> own_pending)
    else $error("cr_valid_i with no outstanding snoop");
  a_cd_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cd_valid_i |-> cd_pending)
    else $error("cd_valid_i with no data-carrying snoop");
`endif

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Scoreboard bench for ccu_snoop_arbiter: AC issuers are queued as expected
// CR owners, data-carrying CRs queue expected CD owners.
module tb_ccu_snoop_arbiter;
  import ccu_ctrl_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [1:0]             req_ac_valid_i, req_ac_ready_o;
  ccu_ac_chan_t [1:0]     req_ac_i;
  ccu_domain_mask_t [1:0] req_domain_mask_i;
  logic [1:0]             req_cr_valid_o, req_cr_ready_i;
  ccu_cr_resp_t           req_cr_resp_o;
  logic [1:0]             req_cd_valid_o, req_cd_ready_i;
  ccu_cd_chan_t           req_cd_o;
  logic                   ac_valid_o, ac_ready_i;
  ccu_ac_chan_t           ac_o;
  ccu_domain_mask_t       domain_mask_o;
  logic                   cr_valid_i, cr_ready_o;
  ccu_cr_resp_t           cr_resp_i;
  logic                   cd_valid_i, cd_ready_o;
  ccu_cd_chan_t           cd_i;
  logic                   busy_o;

  ccu_snoop_arbiter dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .req_ac_valid_i    (req_ac_valid_i),
    .req_ac_ready_o    (req_ac_ready_o),
    .req_ac_i          (req_ac_i),
    .req_domain_mask_i (req_domain_mask_i),
    .req_cr_valid_o    (req_cr_valid_o),
    .req_cr_ready_i    (req_cr_ready_i),
    .req_cr_resp_o     (req_cr_resp_o),
    .req_cd_valid_o    (req_cd_valid_o),
    .req_cd_ready_i    (req_cd_ready_i),
    .req_cd_o          (req_cd_o),
    .ac_valid_o        (ac_valid_o),
    .ac_ready_i        (ac_ready_i),
    .ac_o              (ac_o),
    .domain_mask_o     (domain_mask_o),
    .cr_valid_i        (cr_valid_i),
    .cr_ready_o        (cr_ready_o),
    .cr_resp_i         (cr_resp_i),
    .cd_valid_i        (cd_valid_i),
    .cd_ready_o        (cd_ready_o),
    .cd_i              (cd_i),
    .busy_o            (busy_o)
  );

  int checks = 0;
  int errors = 0;
  bit own_q[$];
  bit cd_q[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_ac(bit idx, logic [31:0] addr, ccu_domain_mask_t mask);
    req_ac_i[idx].addr     = addr;
    req_domain_mask_i[idx] = mask;
    req_ac_valid_i         = 2'b01 << idx;
    ac_ready_i             = 1'b1;
    #1;
    chk("ac_valid", 64'(ac_valid_o), 64'(1));
    chk("ac_addr", 64'(ac_o.addr), 64'(addr));
    chk("ac_mask", 64'(domain_mask_o), 64'(mask));
    chk("ac_ready", 64'(req_ac_ready_o), 64'(2'b01 << idx));
    own_q.push_back(idx);
    tick();
    req_ac_valid_i = '0;
    ac_ready_i     = 1'b0;
  endtask

  task automatic do_cr(bit dt);
    bit exp;
    exp = own_q.pop_front();
    cr_resp_i              = '0;
    cr_resp_i.DataTransfer = dt;
    cr_valid_i             = 1'b1;
    req_cr_ready_i         = 2'b11;
    #1;
    chk("cr_route", 64'(req_cr_valid_o), 64'(2'b01 << exp));
    chk("cr_ready", 64'(cr_ready_o), 64'(1));
    if (dt) cd_q.push_back(exp);
    tick();
    cr_valid_i = 1'b0;
    cr_resp_i  = '0;
  endtask

  task automatic do_cd(int nbeats);
    bit exp;
    exp = cd_q[0];
    for (int b = 0; b < nbeats; b++) begin
      cd_i.data      = 64'(b + 16);
      cd_i.last      = (b == nbeats - 1);
      cd_valid_i     = 1'b1;
      req_cd_ready_i = 2'b11;
      #1;
      chk("cd_route", 64'(req_cd_valid_o), 64'(2'b01 << exp));
      chk("cd_ready", 64'(cd_ready_o), 64'(1));
      chk("cd_data", req_cd_o.data, 64'(b + 16));
      tick();
    end
    cd_valid_i = 1'b0;
    cd_i       = '0;
    void'(cd_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit exp1;
    req_ac_valid_i = '0; req_ac_i = '0; req_domain_mask_i = '0;
    req_cr_ready_i = '0; req_cd_ready_i = '0;
    ac_ready_i = 1'b0; cr_valid_i = 1'b0; cr_resp_i = '0;
    cd_valid_i = 1'b0; cd_i = '0;
    #3;
    chk("rst_ac_valid", 64'(ac_valid_o), 64'(0));
    chk("rst_ac_ready", 64'(req_ac_ready_o), 64'(0));
    chk("rst_cr_valid", 64'(req_cr_valid_o), 64'(0));
    chk("rst_cd_valid", 64'(req_cd_valid_o), 64'(0));
    chk("rst_cr_ready", 64'(cr_ready_o), 64'(0));
    chk("rst_cd_ready", 64'(cd_ready_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();

    // Both requesters valid from the first cycle.
    req_ac_i[0].addr = 32'h100; req_domain_mask_i[0] = 2'b01;
    req_ac_i[1].addr = 32'h200; req_domain_mask_i[1] = 2'b10;
    req_ac_valid_i = 2'b11;
    ac_ready_i = 1'b1;
    #1;
    chk("arb_c0_addr", 64'(ac_o.addr), 64'h100);
    chk("arb_c0_ready", 64'(req_ac_ready_o), 64'(2'b01));
    own_q.push_back(1'b0);
    tick();
`ifdef CCU_SNOOP_ARB_RR_EN
    exp1 = 1'b1;
`else
    exp1 = 1'b0;
`endif
    #1;
    chk("arb_c1_addr", 64'(ac_o.addr), exp1 ? 64'h200 : 64'h100);
    chk("arb_c1_ready", 64'(req_ac_ready_o), 64'(2'b01 << exp1));
    own_q.push_back(exp1);
    tick();
    req_ac_valid_i = '0; ac_ready_i = 1'b0;
    do_cr(1'b0);
    do_cr(1'b0);

    // Stalled AC from req1 keeps its grant while req0 joins.
    req_ac_i[1].addr = 32'h222; req_domain_mask_i[1] = 2'b10;
    req_ac_i[0].addr = 32'h111; req_domain_mask_i[0] = 2'b01;
    req_ac_valid_i = 2'b10;
    #1;
    chk("lock_c0_addr", 64'(ac_o.addr), 64'h222);
    tick();
    req_ac_valid_i = 2'b11;
    for (int c = 1; c < 3; c++) begin
      #1;
      chk("lock_addr", 64'(ac_o.addr), 64'h222);
      chk("lock_mask", 64'(domain_mask_o), 64'(2'b10));
      chk("lock_busy", 64'(busy_o), 64'(1));
      tick();
    end
    ac_ready_i = 1'b1;
    #1;
    chk("lock_hs_addr", 64'(ac_o.addr), 64'h222);
    chk("lock_hs_ready", 64'(req_ac_ready_o), 64'(2'b10));
    own_q.push_back(1'b1);
    tick();
    req_ac_valid_i = 2'b01;
    #1;
    chk("after_lock_addr", 64'(ac_o.addr), 64'h111);
    chk("after_lock_ready", 64'(req_ac_ready_o), 64'(2'b01));
    own_q.push_back(1'b0);
    tick();
    req_ac_valid_i = '0; ac_ready_i = 1'b0;
    do_cr(1'b0);
    do_cr(1'b0);

    // In-order CR routing and a 4-beat CD to req1.
    issue_ac(1'b0, 32'h300, 2'b01);
    issue_ac(1'b1, 32'h310, 2'b11);
    issue_ac(1'b0, 32'h320, 2'b01);
    do_cr(1'b0);
    do_cr(1'b1);
    do_cr(1'b0);
    do_cd(4);
    #1;
    chk("cd_done_busy", 64'(busy_o), 64'(0));

    // Owner FIFO full: AC blocked, resumes the cycle after a CR pop.
    issue_ac(1'b0, 32'h400, 2'b01);
    issue_ac(1'b1, 32'h410, 2'b10);
    issue_ac(1'b0, 32'h420, 2'b01);
    issue_ac(1'b1, 32'h430, 2'b10);
    req_ac_i[0].addr = 32'h440;
    req_ac_valid_i = 2'b01;
    ac_ready_i = 1'b1;
    #1;
    chk("full_ac_valid", 64'(ac_valid_o), 64'(0));
    chk("full_ac_ready", 64'(req_ac_ready_o), 64'(0));
    tick();
    cr_resp_i = '0;
    cr_valid_i = 1'b1;
    req_cr_ready_i = 2'b11;
    #1;
    chk("full_cr_route", 64'(req_cr_valid_o), 64'(2'b01 << own_q[0]));
    chk("full_cr_ready", 64'(cr_ready_o), 64'(1));
    chk("full_pop_ac_valid", 64'(ac_valid_o), 64'(0));
    void'(own_q.pop_front());
    tick();
    cr_valid_i = 1'b0;
    #1;
    chk("resume_ac_valid", 64'(ac_valid_o), 64'(1));
    chk("resume_ac_ready", 64'(req_ac_ready_o), 64'(2'b01));
    chk("resume_ac_addr", 64'(ac_o.addr), 64'h440);
    own_q.push_back(1'b0);
    tick();
    req_ac_valid_i = '0; ac_ready_i = 1'b0;
    repeat (4) do_cr(1'b1);

    // CD owner FIFO now full: a data-carrying CR must wait for a CD last beat.
    issue_ac(1'b0, 32'h500, 2'b01);
    cr_resp_i = '0;
    cr_resp_i.DataTransfer = 1'b1;
    cr_valid_i = 1'b1;
    req_cr_ready_i = 2'b11;
    #1;
    chk("cdfull_cr_route", 64'(req_cr_valid_o), 64'(2'b01));
    chk("cdfull_cr_ready", 64'(cr_ready_o), 64'(0));
    tick();
    #1;
    chk("cdfull_cr_ready2", 64'(cr_ready_o), 64'(0));
    cd_i.data = 64'h77; cd_i.last = 1'b1;
    cd_valid_i = 1'b1;
    req_cd_ready_i = 2'b11;
    #1;
    chk("cdfull_cd_route", 64'(req_cd_valid_o), 64'(2'b01 << cd_q[0]));
    chk("cdfull_cd_ready", 64'(cd_ready_o), 64'(1));
    chk("cdfull_cr_ready3", 64'(cr_ready_o), 64'(0));
    tick();
    void'(cd_q.pop_front());
    cd_valid_i = 1'b0; cd_i = '0;
    #1;
    chk("cdfree_cr_ready", 64'(cr_ready_o), 64'(1));
    cd_q.push_back(own_q.pop_front());
    tick();
    cr_valid_i = 1'b0; cr_resp_i = '0;
    repeat (4) do_cd(1);
    #1;
    chk("drain_busy", 64'(busy_o), 64'(0));

    // Reset in the middle of a CD burst.
    issue_ac(1'b1, 32'h600, 2'b10);
    do_cr(1'b1);
    cd_i.last = 1'b0; cd_valid_i = 1'b1; req_cd_ready_i = 2'b11;
    #1;
    chk("mid_cd_route", 64'(req_cd_valid_o), 64'(2'b10));
    tick();
    #1;
    chk("mid_cd_route2", 64'(req_cd_valid_o), 64'(2'b10));
    rst_ni = 1'b0;
    #1;
    chk("mrst_cd_valid", 64'(req_cd_valid_o), 64'(0));
    chk("mrst_cd_ready", 64'(cd_ready_o), 64'(0));
    chk("mrst_busy", 64'(busy_o), 64'(0));
    own_q.delete();
    cd_q.delete();
    cd_valid_i = 1'b0; cd_i = '0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    issue_ac(1'b0, 32'h700, 2'b01);
    do_cr(1'b0);
    #1;
    chk("post_rst_busy", 64'(busy_o), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccu_snoop_arbiter.md
Name: ccu_snoop_arbiter

Overview:
Shares the single snoop-crossbar port (AC/CR/CD) between NumReq snoop controllers, e.g. the read-snoop FSM at index 0 and the write-snoop FSM at index 1. Arbitrates AC requests and forwards the domain mask together with the AC that carries it. Records the owner of each issued snoop and routes in-order CR and CD responses back to that owner. Sits between the CCU control FSMs and the snoop crossbar.

Parameters:
NumReq, 2, number of snoop requesters (at least 2)
MaxOutstanding, 4, depth of the AC-owner FIFO and of the CD-owner FIFO
ac_chan_t, logic, AC payload type
cr_resp_t, logic, CR response type; has field DataTransfer
cd_chan_t, logic, CD payload type; has field last
domain_mask_t, logic, snoop domain mask type

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_ac_valid_i  in  NumReq  AC valid per requester
req_ac_ready_o  out  NumReq  AC ready per requester
req_ac_i  in  NumReq x ac_chan_t  AC payload per requester
req_domain_mask_i  in  NumReq x domain_mask_t  domain mask per requester
req_cr_valid_o  out  NumReq  routed CR valid
req_cr_ready_i  in  NumReq  CR ready per requester
req_cr_resp_o  out  cr_resp_t  CR response, broadcast to all requesters
req_cd_valid_o  out  NumReq  routed CD valid
req_cd_ready_i  in  NumReq  CD ready per requester
req_cd_o  out  cd_chan_t  CD payload, broadcast to all requesters
ac_valid_o / ac_ready_i / ac_o  out/in/out  1/1/ac_chan_t  AC towards the crossbar
domain_mask_o  out  domain_mask_t  mask of the granted AC
cr_valid_i / cr_ready_o / cr_resp_i  in/out/in  1/1/cr_resp_t  CR from the crossbar
cd_valid_i / cd_ready_o / cd_i  in/out/in  1/1/cd_chan_t  CD from the crossbar
busy_o  out  1  at least one snoop outstanding or a grant is locked

Behaviour:
- Reset: grant lock cleared, both FIFOs empty, RR pointer = 0. All valid and ready outputs = 0; busy_o = 0.
- AC arbitration is combinational: the grant is selected from req_ac_valid_i.
- AC gating: ac_valid_o = any requester valid && !own_fifo_full.
- AC payload: ac_o and domain_mask_o come from the granted index; req_ac_ready_o[g] = ac_ready_i && !own_fifo_full.
- Grant lock: if ac_valid_o=1 and ac_ready_i=0, the grant index registers and holds until the AC handshake. A lower index raising valid meanwhile does not change ac_o. This keeps AXI payload stability.
- AC handshake: pushes the granted index into the own-FIFO. Zero-cycle latency from requester to crossbar.
- CR routing:
  - req_cr_valid_o[head] = cr_valid_i && own_fifo_valid; all other bits are 0.
  - cr_ready_o = req_cr_ready_i[head] && own_fifo_valid && (!cd_fifo_full || !cr_resp_i.DataTransfer).
- CR handshake: pops the own-FIFO. If DataTransfer=1, pushes head into the CD-FIFO in the same cycle.
- CD routing: req_cd_valid_o[cd_head] = cd_valid_i && cd_fifo_valid; cd_ready_o = req_cd_ready_i[cd_head] && cd_fifo_valid.
- CD-FIFO pops only on a CD handshake with cd_i.last=1. A multi-beat CD stays routed to one owner.
- cr_valid_i or cd_valid_i arriving with the matching FIFO empty is a protocol error: it is dropped, ready stays 0, and a simulation assertion fires.
- Full FIFO: push is blocked while full, even if a pop occurs in the same cycle. Ready is derived from the registered full flag and has no comb path through pop.
- Empty FIFO: simultaneous push and pop on an empty FIFO is not possible; data is visible one cycle after push.
- Simultaneous events: an AC push, CR pop and CD pop can occur in the same cycle; each FIFO is updated independently.
- Reset mid-operation discards all outstanding ownership. Requesters reset concurrently.

Optional Feature:
CCU_SNOOP_ARB_RR_EN
- Defined: round-robin arbitration. The pointer advances to (granted index + 1) mod NumReq on each AC handshake. Search starts at the pointer.
- Undefined: fixed priority, lowest index wins; the pointer register is removed.
- Lock behaviour is identical in both modes.

Decomposition:
- ccu_ctrl_pkg gets: typedef req_idx_t = logic[$clog2(NumReq)-1:0] as a module localparam type; constant CCU_SNOOP_MAX_OUTSTANDING = 4.
- Both owner queues use the common stream_fifo.
- One sub-module is natural: ccu_snoop_owner_router. It is a single owner FIFO plus valid/ready demux, instantiated twice: once for CR, once for CD with pop-on-last.

Test Plan:
- Req0 and req1 both valid in cycle 0 with ac_ready_i=1 -> RR: grants 0 then 1 in consecutive cycles; fixed priority: 0 granted while valid.
- Req1 valid, ac_ready_i low for 3 cycles, req0 raises valid in cycle 1 -> ac_o stays req1's address for all 3 cycles, and domain_mask_o stays req1's mask; req0 is granted after the handshake.
- Issue AC from 0,1,0; return CR DataTransfer=0,1,0 -> req_cr_valid_o pulses 0b01, 0b10, 0b01 in order. A 4-beat CD goes to req1 only and the CD-FIFO pops on beat 4.
- 4 ACs issued with no CR -> 5th AC sees req_ac_ready_o=0 and ac_valid_o=0. One CR handshake -> AC resumes next cycle.
- CD-FIFO holds 4 entries, CR with DataTransfer=1 arrives -> cr_ready_o=0 until one CD last beat completes.
- Assert rst_ni mid-CD burst -> all valids 0 in the same cycle, busy_o=0, the next AC is granted normally.
